// File: rtl/shift_frame_tx.sv
// ============================================================================
// Module   : shift_frame_tx
// Brief    : Parallel-to-serial framing transmitter (start, WIDTH data bits,
//            optional even parity, stop). Parity enabled by defining
//            SHIFT_FRAME_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             lsb_first,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int                   c_bit_w       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] c_period_load = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]   c_last_bit    = c_bit_w'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SHIFT_FRAME_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_period_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]     r_shift;
    logic                 r_lsb_first;
`ifdef SHIFT_FRAME_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic [WIDTH-1:0] w_next_shift;
    logic             w_next_bit;
    logic             w_first_bit;
    logic             w_period_end;

    // The shift register is only advanced between data bits; the outgoing
    // bit is always taken from the end selected by the latched bit order.
    assign w_next_shift = r_lsb_first ? {1'b0, r_shift[WIDTH-1:1]}
                                      : {r_shift[WIDTH-2:0], 1'b0};
    assign w_next_bit   = r_lsb_first ? w_next_shift[0] : w_next_shift[WIDTH-1];
    assign w_first_bit  = r_lsb_first ? r_shift[0] : r_shift[WIDTH-1];
    assign w_period_end = (r_period_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_period_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_lsb_first  <= 1'b0;
`ifdef SHIFT_FRAME_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
            serial_out   <= 1'b1;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!enable) begin
                s_ready <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        serial_out <= 1'b1;
                        busy       <= 1'b0;
                        if (s_valid && s_ready) begin
                            r_shift      <= s_data;
                            r_lsb_first  <= lsb_first;
`ifdef SHIFT_FRAME_TX_PARITY_EN
                            r_parity     <= ^s_data;
`endif
                            r_period_cnt <= c_period_load;
                            r_bit_cnt    <= '0;
                            r_state      <= ST_START;
                            serial_out   <= 1'b0;
                            s_ready      <= 1'b0;
                            busy         <= 1'b1;
                        end else begin
                            s_ready <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (w_period_end) begin
                            r_state      <= ST_DATA;
                            r_period_cnt <= c_period_load;
                            r_bit_cnt    <= '0;
                            serial_out   <= w_first_bit;
                        end else begin
                            r_period_cnt <= r_period_cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (w_period_end) begin
                            r_period_cnt <= c_period_load;
                            if (r_bit_cnt == c_last_bit) begin
`ifdef SHIFT_FRAME_TX_PARITY_EN
                                r_state    <= ST_PARITY;
                                serial_out <= r_parity;
`else
                                r_state    <= ST_STOP;
                                serial_out <= 1'b1;
`endif
                            end else begin
                                r_bit_cnt  <= r_bit_cnt + 1'b1;
                                r_shift    <= w_next_shift;
                                serial_out <= w_next_bit;
                            end
                        end else begin
                            r_period_cnt <= r_period_cnt - 1'b1;
                        end
                    end
`ifdef SHIFT_FRAME_TX_PARITY_EN
                    ST_PARITY: begin
                        if (w_period_end) begin
                            r_state      <= ST_STOP;
                            r_period_cnt <= c_period_load;
                            serial_out   <= 1'b1;
                        end else begin
                            r_period_cnt <= r_period_cnt - 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (w_period_end) begin
                            // Ready is raised here so a waiting word is taken
                            // on the very next edge, leaving one idle cycle.
                            r_state    <= ST_IDLE;
                            r_bit_cnt  <= '0;
                            serial_out <= 1'b1;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            s_ready    <= 1'b1;
                        end else begin
                            r_period_cnt <= r_period_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        serial_out <= 1'b1;
                        busy       <= 1'b0;
                        s_ready    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/shift_frame_tx.md
Name: shift_frame_tx

Overview:
Parallel-to-serial framing transmitter that consumes whole words over a valid/ready handshake and shifts them out one bit at a time.
- Frame: start bit, WIDTH data bits, optional parity bit, stop bit; each bit held for a fixed number of clocks.
- Sits downstream of the register/shift stages and feeds an external serial line or a serial-in port of another block.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1).
- CNT_WIDTH, 16, width of the bit-period counter; must satisfy 2**CNT_WIDTH > CLKS_PER_BIT.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  global advance enable; low freezes the block.
- lsb_first  input  1  bit order; sampled only at word acceptance.
- s_valid  input  1  upstream word valid.
- s_data  input  WIDTH  upstream word.
- s_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (asynchronous, any time including mid-frame): state IDLE, serial_out=1, s_ready=0, busy=0, done=0, bit counter=0, period counter=0, shift register=0.
  - s_ready rises on the first clock after reset release, if enable=1.
  - Any partial frame is abandoned. No word is lost from upstream's view, because the handshake had already completed.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - s_ready=1 while enable=1; serial_out=1.
  - Acceptance occurs on an edge where s_valid=1, s_ready=1 and enable=1. On that edge: latch s_data into the shift register, latch lsb_first, load period counter, go to START.
  - On the same edge s_ready drops to 0 and busy rises to 1.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Send WIDTH bits, each for CLKS_PER_BIT cycles.
  - Bit order: lsb_first=1 sends bit0 first and shifts right; lsb_first=0 sends bit WIDTH-1 first and shifts left.
  - The bit counter counts 0..WIDTH-1. After the last bit, go to PARITY (feature enabled) or STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly one cycle.
  - In that same cycle s_ready=1, so back-to-back frames are separated by exactly one idle cycle.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles from acceptance edge to the STOP→IDLE edge, or (WIDTH+3)*CLKS_PER_BIT with parity.
- enable=0, in any state:
  - State, counters, shift register and serial_out hold; s_ready=0.
  - A done pulse already asserted still deasserts after one cycle.
  - Resuming continues exactly where the block froze; the bit period is stretched by the frozen cycles.
- Changes to s_data and lsb_first after acceptance have no effect on the frame in flight.
- s_valid is ignored outside IDLE.
- Period counter: counts down from CLKS_PER_BIT-1 to 0. A bit transition occurs on the edge where the counter is 0 and enable=1. CLKS_PER_BIT=1 means one bit per cycle.

Optional Feature:
- Macro: SHIFT_FRAME_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA. serial_out = XOR of all WIDTH latched data bits (even parity) for CLKS_PER_BIT cycles.
  - The parity value is computed at acceptance and is independent of lsb_first.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with enable=1 → serial_out=1, busy=0, done=0 during reset; s_ready=1 on the first edge after release.
- LSB-first word: s_data=0x4B, lsb_first=1, CLKS_PER_BIT=4, no parity → serial_out sequence, each bit held 4 cycles: 0 (start), 1,1,0,1,0,0,1,0, then 1 (stop). done pulses exactly 40 cycles after acceptance; s_ready=1 in the same cycle.
- MSB-first word: s_data=0x4B, lsb_first=0 → data bits 0,1,0,0,1,0,1,1. Toggling lsb_first and s_data mid-frame leaves the sequence unchanged.
- Back-to-back frames: s_valid held high with 0x01 then 0x80 → second acceptance occurs on the done cycle; exactly one idle-high cycle between the stop bit and the next start bit.
- Stall and reset: drop enable for 5 cycles during data bit 3 → serial_out and busy hold, s_ready=0, frame completes 5 cycles late with correct bits. Assert rst_n mid-DATA → serial_out=1 immediately, state IDLE, no done pulse.
- Parity (with SHIFT_FRAME_TX_PARITY_EN): s_data=0x07 → parity bit 1 before the stop bit, frame 44 cycles. s_data=0x4B → parity bit 0.
